// File: rtl/jam_param.sv
`default_nettype none
// ============================================================================
//  Module   : jam_param
//  Function : Exhaustive job-assignment engine. Loads an N x N cost matrix
//             from an external synchronous cost ROM, walks all N! worker-to-
//             job permutations in lexicographic order and reports the minimum
//             total cost, the number of permutations reaching it (saturating)
//             and, optionally, the lexicographically first optimal permutation.
//  Options  : define JAM_BEST_PERM_EN to add the BestPerm output port.
//  Revision : 1.0 - initial release
// ============================================================================
module jam_param #(
    parameter int N       = 8,
    parameter int COST_W  = 7,
    parameter int COUNT_W = 16,
    localparam int IW     = (N > 2) ? $clog2(N) : 1,
    localparam int TW     = COST_W + $clog2(N)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    output logic               busy,
    output logic [IW-1:0]      W,
    output logic [IW-1:0]      J,
    input  logic [COST_W-1:0]  Cost,
    output logic [TW-1:0]      MinCost,
    output logic [COUNT_W-1:0] MatchCount,
    output logic               Valid
`ifdef JAM_BEST_PERM_EN
    ,
    output logic [N*IW-1:0]    BestPerm
`endif
);

    // Load counter spans 0..N*N: one extra cycle to catch the last ROM word.
    localparam int CW = $clog2(N * N + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_EVAL = 3'd2,
        S_CMP  = 3'd3,
        S_NEXT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t               state_q;
    logic [COST_W-1:0]    mem_q [N][N];
    logic [IW-1:0]        perm_q [N];
    logic [IW-1:0]        perm_d [N];
    logic [IW-1:0]        perm_sw [N];
    logic                 has_next;
    logic [IW-1:0]        piv_i;
    logic [IW-1:0]        piv_j;
    logic [TW-1:0]        total_d;
    logic [TW-1:0]        total_q;
    logic [IW-1:0]        w_q;
    logic [IW-1:0]        j_q;
    logic [IW-1:0]        cw_q;
    logic [IW-1:0]        cj_q;
    logic [CW-1:0]        cnt_q;
    logic [TW-1:0]        min_q;
    logic [COUNT_W-1:0]   match_q;
    logic                 valid_q;
    logic                 busy_q;
`ifdef JAM_BEST_PERM_EN
    logic [N*IW-1:0]      best_q;
`endif

    assign busy       = busy_q;
    assign W          = w_q;
    assign J          = j_q;
    assign MinCost    = min_q;
    assign MatchCount = match_q;
    assign Valid      = valid_q;
`ifdef JAM_BEST_PERM_EN
    assign BestPerm   = best_q;
`endif

    // Total cost of the current permutation; TW bits cannot overflow.
    always_comb begin
        total_d = '0;
        for (int k = 0; k < N; k++) begin
            total_d = total_d + TW'(mem_q[k][perm_q[k]]);
        end
    end

    // Next lexicographic permutation: pivot search, swap, then suffix reversal.
    always_comb begin
        has_next = 1'b0;
        piv_i    = '0;
        piv_j    = '0;
        for (int k = 0; k < N - 1; k++) begin
            if (perm_q[k] < perm_q[k + 1]) begin
                has_next = 1'b1;
                piv_i    = IW'(k);
            end
        end
        for (int k = 0; k < N; k++) begin
            if ((IW'(k) > piv_i) && (perm_q[k] > perm_q[piv_i])) begin
                piv_j = IW'(k);
            end
        end
        perm_sw        = perm_q;
        perm_sw[piv_i] = perm_q[piv_j];
        perm_sw[piv_j] = perm_q[piv_i];
        perm_d         = perm_sw;
        // Positions after the pivot are mirrored: k maps to N-1-(k-piv_i-1).
        for (int k = 0; k < N; k++) begin
            if (IW'(k) > piv_i) begin
                perm_d[k] = perm_sw[IW'(N + int'(piv_i) - k)];
            end
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            w_q     <= '0;
            j_q     <= '0;
            cw_q    <= '0;
            cj_q    <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            min_q   <= '1;
            match_q <= '0;
            for (int k = 0; k < N; k++) begin
                perm_q[k] <= IW'(k);
            end
`ifdef JAM_BEST_PERM_EN
            for (int k = 0; k < N; k++) begin
                best_q[k*IW +: IW] <= IW'(k);
            end
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        min_q   <= '1;
                        match_q <= '0;
                        w_q     <= '0;
                        j_q     <= '0;
                        cnt_q   <= '0;
                        for (int k = 0; k < N; k++) begin
                            perm_q[k] <= IW'(k);
                        end
                        state_q <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Remember this cycle's address; its data returns next cycle.
                    cw_q <= w_q;
                    cj_q <= j_q;
                    if (cnt_q != '0) begin
                        mem_q[cw_q][cj_q] <= Cost;
                    end
                    // Row-major walk that parks on (N-1,N-1).
                    if (j_q != IW'(N - 1)) begin
                        j_q <= j_q + IW'(1);
                    end else if (w_q != IW'(N - 1)) begin
                        w_q <= w_q + IW'(1);
                        j_q <= '0;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N * N)) begin
                        state_q <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    total_q <= total_d;
                    state_q <= S_CMP;
                end

                S_CMP: begin
                    if (total_q < min_q) begin
                        min_q   <= total_q;
                        match_q <= COUNT_W'(1);
`ifdef JAM_BEST_PERM_EN
                        for (int k = 0; k < N; k++) begin
                            best_q[k*IW +: IW] <= perm_q[k];
                        end
`endif
                    end else if ((total_q == min_q) && (match_q != {COUNT_W{1'b1}})) begin
                        match_q <= match_q + COUNT_W'(1);
                    end
                    state_q <= S_NEXT;
                end

                S_NEXT: begin
                    if (has_next) begin
                        perm_q  <= perm_d;
                        state_q <= S_EVAL;
                    end else begin
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_jam_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jam_param
//  Function : Self-checking bench for jam_param at N=3, N=4 and N=5
//             (COUNT_W=4). A brute-force reference model enumerates every
//             N^N job tuple in lexicographic order, keeps the permutations,
//             and derives minimum, tie count (saturated) and first optimum.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jam_param;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  rom [8][8];

    logic        start3, busy3, Valid3;
    logic [1:0]  W3, J3;
    logic [6:0]  Cost3;
    logic [8:0]  Min3;
    logic [15:0] Cnt3;

    logic        start4, busy4, Valid4;
    logic [1:0]  W4, J4;
    logic [6:0]  Cost4;
    logic [8:0]  Min4;
    logic [15:0] Cnt4;

    logic        start5, busy5, Valid5;
    logic [2:0]  W5, J5;
    logic [6:0]  Cost5;
    logic [9:0]  Min5;
    logic [3:0]  Cnt5;

`ifdef JAM_BEST_PERM_EN
    logic [5:0]  Best3;
    logic [7:0]  Best4;
    logic [14:0] Best5;
`endif

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    jam_param #(.N(3)) u3 (
        .CLK(CLK), .RST(RST), .start(start3), .busy(busy3), .W(W3), .J(J3),
        .Cost(Cost3), .MinCost(Min3), .MatchCount(Cnt3), .Valid(Valid3)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(Best3)
`endif
    );

    jam_param #(.N(4)) u4 (
        .CLK(CLK), .RST(RST), .start(start4), .busy(busy4), .W(W4), .J(J4),
        .Cost(Cost4), .MinCost(Min4), .MatchCount(Cnt4), .Valid(Valid4)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(Best4)
`endif
    );

    jam_param #(.N(5), .COUNT_W(4)) u5 (
        .CLK(CLK), .RST(RST), .start(start5), .busy(busy5), .W(W5), .J(J5),
        .Cost(Cost5), .MinCost(Min5), .MatchCount(Cnt5), .Valid(Valid5)
`ifdef JAM_BEST_PERM_EN
        , .BestPerm(Best5)
`endif
    );

    // Synchronous cost ROM: data for last cycle's address.
    always @(posedge CLK) begin
        Cost3 <= rom[W3][J3];
        Cost4 <= rom[W4][J4];
        Cost5 <= rom[W5][J5];
    end

    // what: 0 Valid, 1 busy, 2 MinCost, 3 MatchCount, 4 BestPerm, 5 W, 6 J
    function automatic logic [63:0] obs(input int id, input int what);
        logic [63:0] r;
        r = '0;
        case (id)
            3: case (what)
                0: r = 64'(Valid3);
                1: r = 64'(busy3);
                2: r = 64'(Min3);
                3: r = 64'(Cnt3);
`ifdef JAM_BEST_PERM_EN
                4: r = 64'(Best3);
`endif
                5: r = 64'(W3);
                6: r = 64'(J3);
                default: r = '0;
            endcase
            4: case (what)
                0: r = 64'(Valid4);
                1: r = 64'(busy4);
                2: r = 64'(Min4);
                3: r = 64'(Cnt4);
`ifdef JAM_BEST_PERM_EN
                4: r = 64'(Best4);
`endif
                5: r = 64'(W4);
                6: r = 64'(J4);
                default: r = '0;
            endcase
            default: case (what)
                0: r = 64'(Valid5);
                1: r = 64'(busy5);
                2: r = 64'(Min5);
                3: r = 64'(Cnt5);
`ifdef JAM_BEST_PERM_EN
                4: r = 64'(Best5);
`endif
                5: r = 64'(W5);
                6: r = 64'(J5);
                default: r = '0;
            endcase
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic set_start(input int id, input logic v);
        case (id)
            3:       start3 = v;
            4:       start4 = v;
            default: start5 = v;
        endcase
    endtask

    task automatic pulse(input int id);
        set_start(id, 1'b1);
        @(negedge CLK);
        set_start(id, 1'b0);
    endtask

    task automatic fill(input int mode, input int maxv);
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                case (mode)
                    0:       rom[a][b] = 7'(maxv);
                    1:       rom[a][b] = 7'($urandom_range(0, maxv));
                    default: rom[a][b] = (a == b) ? 7'd1 : 7'd9;
                endcase
            end
        end
    endtask

    // Waits for Valid within the guaranteed latency bound.
    task automatic wait_valid(input int n, input string tag);
        int f;
        int bound;
        int cyc;
        f = 1;
        for (int k = 2; k <= n; k++) f *= k;
        bound = n * n + 4 + f * (3 * n + 4);
        cyc = 0;
        while (obs(n, 0) !== 64'd1 && cyc <= bound) begin
            @(negedge CLK);
            cyc++;
        end
        check({tag, "_latency_ok"}, 64'(cyc <= bound), 64'd1);
    endtask

    // Reference: scan all n^n tuples (worker 0 most significant), keep permutations.
    task automatic model(input int n, input int cw, output logic [63:0] mn,
                         output logic [63:0] cnt, output logic [63:0] best);
        int iw, lim, v, sum;
        int d [8];
        bit [7:0] used;
        bit ok;
        iw  = (n > 2) ? $clog2(n) : 1;
        lim = 1;
        for (int k = 0; k < n; k++) lim *= n;
        mn = '1; cnt = 0; best = 0;
        for (int x = 0; x < lim; x++) begin
            v = x; sum = 0; used = '0; ok = 1'b1;
            for (int k = n - 1; k >= 0; k--) begin
                d[k] = v % n;
                v    = v / n;
            end
            for (int k = 0; k < n; k++) begin
                if (used[d[k]]) ok = 1'b0;
                used[d[k]] = 1'b1;
                sum += int'(rom[k][d[k]]);
            end
            if (ok) begin
                if (64'(sum) < mn) begin
                    mn = 64'(sum); cnt = 1; best = 0;
                    for (int k = 0; k < n; k++) best |= 64'(d[k]) << (k * iw);
                end else if (64'(sum) == mn) begin
                    cnt++;
                end
            end
        end
        if (cnt > (64'd1 << cw) - 1) cnt = (64'd1 << cw) - 1;
    endtask

    task automatic run_random(input int n, input int maxv, input int r);
        logic [63:0] mn, cnt, best;
        string t;
        t = $sformatf("rnd_n%0d_%0d", n, r);
        fill(1, maxv);
        model(n, (n == 5) ? 4 : 16, mn, cnt, best);
        pulse(n);
        wait_valid(n, t);
        check({t, "_min"}, obs(n, 2), mn);
        check({t, "_count"}, obs(n, 3), cnt);
`ifdef JAM_BEST_PERM_EN
        check({t, "_best"}, obs(n, 4), best);
`endif
    endtask

    initial begin
        RST = 1'b1; start3 = 1'b0; start4 = 1'b0; start5 = 1'b0;
        fill(0, 0);
        repeat (3) @(negedge CLK);

        // Reset state
        check("rst_valid", obs(3, 0), 64'd0);
        check("rst_busy", obs(3, 1), 64'd0);
        check("rst_min3", obs(3, 2), 64'd511);
        check("rst_count", obs(3, 3), 64'd0);
        check("rst_w", obs(3, 5), 64'd0);
        check("rst_j", obs(3, 6), 64'd0);
        check("rst_min5", obs(5, 2), 64'd1023);
`ifdef JAM_BEST_PERM_EN
        check("rst_best3", obs(3, 4), 64'h24);
`endif
        RST = 1'b0;
        @(negedge CLK);

        // N=3 graded matrix: unique optimum worker0->2, 1->1, 2->0
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) rom[a][b] = 7'((a + 1) * (b + 1));
        pulse(3);
        check("t1_busy", obs(3, 1), 64'd1);
        wait_valid(3, "t1");
        check("t1_min", obs(3, 2), 64'd10);
        check("t1_count", obs(3, 3), 64'd1);
        check("t1_busy_low", obs(3, 1), 64'd0);
        check("t1_w_hold", obs(3, 5), 64'd2);
        check("t1_j_hold", obs(3, 6), 64'd2);
`ifdef JAM_BEST_PERM_EN
        check("t1_best", obs(3, 4), 64'h06);
`endif

        // N=4 all fives: every permutation ties
        fill(0, 5);
        pulse(4);
        wait_valid(4, "t2");
        check("t2_min", obs(4, 2), 64'd20);
        check("t2_count", obs(4, 3), 64'd24);
`ifdef JAM_BEST_PERM_EN
        check("t2_best", obs(4, 4), 64'hE4);
`endif
        repeat (5) @(negedge CLK);
        check("t2_valid_hold", obs(4, 0), 64'd1);
        check("t2_busy_hold", obs(4, 1), 64'd0);

        // N=5 zeros: 120 ties saturate a 4-bit counter
        fill(0, 0);
        pulse(5);
        wait_valid(5, "t3");
        check("t3_min", obs(5, 2), 64'd0);
        check("t3_count_sat", obs(5, 3), 64'd15);

        // Back-to-back on N=3 with a diagonal matrix; stray start mid-run
        fill(2, 0);
        pulse(3);
        check("t4_valid_drop", obs(3, 0), 64'd0);
        check("t4_busy", obs(3, 1), 64'd1);
        repeat (15) @(negedge CLK);
        pulse(3);
        wait_valid(3, "t4");
        check("t4_min", obs(3, 2), 64'd3);
        check("t4_count", obs(3, 3), 64'd1);
`ifdef JAM_BEST_PERM_EN
        check("t4_best", obs(3, 4), 64'h24);
`endif

        // Reset while evaluating, then a clean run
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++) rom[a][b] = 7'((a + 1) * (b + 1));
        pulse(3);
        repeat (10) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("t5_valid", obs(3, 0), 64'd0);
        check("t5_busy", obs(3, 1), 64'd0);
        check("t5_min", obs(3, 2), 64'd511);
        check("t5_count", obs(3, 3), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        pulse(3);
        wait_valid(3, "t5b");
        check("t5b_min", obs(3, 2), 64'd10);
        check("t5b_count", obs(3, 3), 64'd1);

        // Randomized matrices against the reference model
        for (int r = 0; r < 6; r++) begin
            run_random(3, 127, r);
            run_random(4, 3, r);
            run_random(5, 1, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jam_param.md
Name: jam_param

Overview:
- Parametrised job-assignment engine. It loads an N x N cost matrix from the external cost ROM over the W/J address interface.
- It exhaustively enumerates all N! worker-to-job permutations in lexicographic order and reports three results: the minimum total cost, the number of permutations achieving it, and the first such permutation.
- Unlike the fixed 8x8 contest machine it supports a start/busy handshake, repeated runs without reset, and MatchCount saturation.

Parameters:
- N, 8, number of workers = number of jobs; legal 2..8.
- COST_W, 7, width of one cost entry.
- COUNT_W, 16, width of MatchCount; saturates at 2^COUNT_W-1.
- Derived, not overridable: IW = max(1, ceil(log2 N)); TW = COST_W + ceil(log2 N).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset.
- start  in  1  run request; sampled only when busy=0.
- busy  out  1  high from the cycle after an accepted start until Valid rises.
- W  out  IW  worker index of the cost-ROM address.
- J  out  IW  job index of the cost-ROM address.
- Cost  in  COST_W  ROM data for the {W,J} driven in the previous cycle.
- MinCost  out  TW  minimum total cost.
- MatchCount  out  COUNT_W  number of permutations with total cost equal to MinCost.
- Valid  out  1  results valid; level signal.

Behaviour:
- Reset is RST, synchronous, active-high; clock is CLK. All state is on the CLK rising edge.
- Reset values: busy=0, Valid=0, W=0, J=0, MinCost=all ones, MatchCount=0, internal permutation = identity (perm[k]=k). FSM goes to IDLE.
- A reset mid-run aborts the run immediately, and no result is produced.
- FSM states: IDLE, LOAD, EVAL, CMP, NEXT, DONE.
- IDLE:
  - When start=1: clear Valid, MinCost=all ones, MatchCount=0, perm=identity, W=J=0; go to LOAD.
  - start is ignored while busy=1.
  - start asserted while Valid=1 starts a new run; Valid drops on the next edge.
- LOAD:
  - {W,J} steps row-major, J fastest, from (0,0) to (N-1,N-1), one address per cycle.
  - Cost is captured one cycle after its address into mem[W][J].
  - LOAD lasts N*N+1 cycles; the last capture is for (N-1,N-1). Then go to EVAL.
  - W and J hold (N-1,N-1) after LOAD until the next start.
- EVAL: total = sum over k of mem[k][perm[k]], computed at TW width with no overflow possible. It may be a single-cycle adder tree or multi-cycle accumulation of at most N cycles; this choice is implementation-defined.
- CMP (one cycle):
  - total < MinCost: MinCost=total, MatchCount=1, best=perm.
  - total == MinCost: MatchCount += 1, saturating at 2^COUNT_W-1. best is unchanged, so it keeps the lexicographically first minimum.
  - total > MinCost: no change.
  - Then go to NEXT.
- NEXT, next lexicographic permutation:
  - Find the largest i with perm[i] < perm[i+1]. If none exists (perm is fully descending), go to DONE.
  - Otherwise find the largest j > i with perm[j] > perm[i], swap perm[i] and perm[j], and reverse perm[i+1..N-1]. Then go to EVAL.
  - The scan may be sequential, at most N cycles each for the i and j searches, plus one cycle for the reverse.
- DONE: Valid=1 and busy=0 on the same edge; go to IDLE. Outputs hold until the next accepted start or RST.
- Bound: Valid rises no later than N*N + 4 + N!*(3N+4) cycles after start is accepted.
- Exactly N! permutations are evaluated per run. The identity is the first, the fully descending permutation is the last, and none is repeated.
- Entries only in index range 0..N-1 are used; no ROM access is made outside 0..N-1.

Optional Feature:
- Macro JAM_BEST_PERM_EN.
- When defined:
  - Extra output port BestPerm, out, N*IW bits. The job assigned to worker k is at bits [k*IW +: IW].
  - BestPerm holds the lexicographically first minimum-cost permutation and is valid while Valid=1.
  - BestPerm resets to the identity encoding.
- When undefined: the port and the best register are absent; all other behaviour is identical.

Test Plan:
- N=3, rows [1,2,3],[2,4,6],[3,6,9] -> MinCost=10, MatchCount=1, BestPerm={2,1,0} (worker0->job2). Valid within the latency bound.
- N=4, all entries 5 -> MinCost=20, MatchCount=24, BestPerm=identity, Valid held high and busy low afterwards.
- N=5, COUNT_W=4, all entries 0 -> 120 matches, MatchCount saturates at 15; MinCost=0.
- N=8, COST_W=7, all entries 127 except mem[k][7-k]=0 -> MinCost=0, MatchCount=1, BestPerm={7,6,5,4,3,2,1,0}.
- Back-to-back runs: after Valid, pulse start with a new matrix (N=3, mem[k][k]=1, others 9) -> Valid drops next edge, MinCost=3, MatchCount=1. A start pulse mid-run is ignored and does not change results.
- RST asserted during EVAL of run 1 -> next edge: Valid=0, busy=0, MinCost=all ones, MatchCount=0. A following clean start produces correct results.
